// File: rtl/p_ffs_iter.sv
// Iterative find-first-set: loads a W-bit vector and emits its set bits lowest-first as one-hot grants.
// Optional binary index output o_y_idx is enabled by defining P_FFS_ITER_IDX_EN.
module p_ffs_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load_vld,
  input  logic [W-1:0] i_load_x,
  output logic         o_load_rdy,
  input  logic         i_flush,
  output logic         o_y_vld,
  output logic [W-1:0] o_y,
  input  logic         i_y_rdy,
  output logic         o_y_last
`ifdef P_FFS_ITER_IDX_EN
  ,
  output logic [$clog2(W)-1:0] o_y_idx
`endif
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_x;
  logic [W-1:0] rest;
  logic         pop;
  logic         load;

  // Two's-complement trick isolates the lowest set bit; rest is the residue minus that bit.
  assign o_y        = r_x & (~r_x + ONE);
  assign rest       = r_x & (r_x - ONE);
  assign o_y_vld    = |r_x;
  assign o_y_last   = o_y_vld & ~(|rest);
  assign o_load_rdy = ~o_y_vld | (o_y_last & i_y_rdy);

  assign pop  = o_y_vld & i_y_rdy;
  assign load = i_load_vld & o_load_rdy;

  // A load arriving with the final pop replaces the residue, giving back-to-back vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
    end else if (i_flush) begin
      r_x <= '0;
    end else if (load) begin
      r_x <= i_load_x;
    end else if (pop) begin
      r_x <= rest;
    end
  end

`ifdef P_FFS_ITER_IDX_EN
  localparam int IW = $clog2(W);

  // o_y is one-hot (or zero), so OR-ing the matching positions yields its binary index.
  always_comb begin
    o_y_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (o_y[i]) begin
        o_y_idx = o_y_idx | IW'(i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_p_ffs_iter.sv
// Scoreboard bench for p_ffs_iter (W=8): accepted loads push their set-bit indices, a monitor pops and checks.
module tb_p_ffs_iter;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         i_load_vld;
  logic [W-1:0] i_load_x;
  logic         o_load_rdy;
  logic         i_flush;
  logic         o_y_vld;
  logic [W-1:0] o_y;
  logic         i_y_rdy;
  logic         o_y_last;
`ifdef P_FFS_ITER_IDX_EN
  logic [$clog2(W)-1:0] o_y_idx;
`endif

  p_ffs_iter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_load_vld (i_load_vld),
    .i_load_x   (i_load_x),
    .o_load_rdy (o_load_rdy),
    .i_flush    (i_flush),
    .o_y_vld    (o_y_vld),
    .o_y        (o_y),
    .i_y_rdy    (i_y_rdy),
    .o_y_last   (o_y_last)
`ifdef P_FFS_ITER_IDX_EN
    ,
    .o_y_idx    (o_y_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  int exp_q[$];   // pending grant indices, ascending

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks what the DUT presents each cycle and retires grants the consumer takes.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("y_vld", {31'd0, o_y_vld}, {31'd0, exp_q.size() != 0});
        chk("load_rdy", {31'd0, o_load_rdy},
            {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && i_y_rdy)});
        if (exp_q.size() == 0) begin
          chk("y_idle", {24'd0, o_y}, 32'd0);
          chk("last_idle", {31'd0, o_y_last}, 32'd0);
`ifdef P_FFS_ITER_IDX_EN
          chk("idx_idle", 32'(o_y_idx), 32'd0);
`endif
        end else begin
          chk("y", {24'd0, o_y}, 32'd1 << exp_q[0]);
          chk("y_last", {31'd0, o_y_last}, {31'd0, exp_q.size() == 1});
`ifdef P_FFS_ITER_IDX_EN
          chk("idx", 32'(o_y_idx), 32'(exp_q[0]));
`endif
          if (i_y_rdy) begin
            $display("grant idx=%0d y=0x%02h last=%0b", exp_q[0], o_y, o_y_last);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus; model update runs after the monitor has retired this cycle's pop.
  task automatic cyc(input logic r, input logic fl, input logic lv,
                     input logic [W-1:0] lx, input logic yr);
    @(posedge clk);
    #1;
    rst = r; i_flush = fl; i_load_vld = lv; i_load_x = lx; i_y_rdy = yr;
    @(negedge clk);
    #1;
    if (r || fl) begin
      exp_q.delete();
    end else if (lv && exp_q.size() == 0) begin
      $display("load x=0x%02h", lx);
      for (int i = 0; i < W; i++) if (lx[i]) exp_q.push_back(i);
    end
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_load_vld = 1'b0; i_load_x = '0; i_y_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic walk
    cyc(0, 0, 1, 8'hA6, 1);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    // Consumer stall
    cyc(0, 0, 1, 8'h81, 0);
    repeat (3) cyc(0, 0, 0, 8'h00, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    // Load on last pop, no bubble
    cyc(0, 0, 1, 8'h03, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'h10, 1);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    // Zero load then full-ones
    cyc(0, 0, 1, 8'h00, 1);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'hFF, 1);
    repeat (9) cyc(0, 0, 0, 8'h00, 1);
    // Flush drops concurrent load
    cyc(0, 0, 1, 8'hF0, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 1, 1, 8'h0F, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    // Reset mid-iteration
    cyc(0, 0, 1, 8'hFF, 1);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'h40, 1);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    // Reset beats a simultaneous load
    cyc(1, 0, 1, 8'h55, 1);
    cyc(0, 0, 0, 8'h00, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 1) == 1), W'($urandom), ($urandom_range(0, 9) < 7));
    end
    repeat (12) cyc(0, 0, 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/p_ffs_iter.md
# p_ffs_iter

Iterative find-first-set engine. Accepts a W-bit vector, then emits every set bit in ascending index order, one per cycle, as a one-hot grant under a valid/ready handshake. Each emitted bit is cleared from an internal residue register. The block is the sequential successor to the combinational FFS primitive in the `p` library. Consumers use it to walk request masks, free lists and pending-event vectors without a wide priority encoder on their own critical path.

## Interface
Parameters:
- `W`, default 32: vector width; legal range 2..1024.

Ports (clock and reset first):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_load_vld`  in  1  load request.
- `i_load_x`  in  W  vector to load; sampled when `i_load_vld & o_load_rdy`.
- `o_load_rdy`  out  1  block can accept a load this cycle.
- `i_flush`  in  1  discard the residue; return to IDLE.
- `o_y_vld`  out  1  `o_y` holds a valid grant.
- `o_y`  out  W  one-hot grant: lowest set bit of the residue; zero when `o_y_vld=0`.
- `i_y_rdy`  in  1  consumer accepts the grant.
- `o_y_last`  out  1  the current grant is the final set bit of the residue.
- `o_y_idx`  out  $clog2(W)  binary index of `o_y`. Present only when `P_FFS_ITER_IDX_EN` is defined.

## Operation
- State register: residue `r_x[W-1:0]`.
- States:
  - IDLE when `r_x==0`.
  - ITER when `r_x!=0`.
  - No other state is held.
- Grant:
  - `o_y = r_x & (~r_x + 1)`.
  - `o_y_vld = (r_x != 0)`.
  - `o_y_last = o_y_vld & ((r_x & (r_x - 1)) == 0)`.
- Pop: `pop = o_y_vld & i_y_rdy`. On pop, `r_x <= r_x & ~o_y`.
- Load ready: `o_load_rdy = ~o_y_vld | (o_y_last & i_y_rdy)`. A new vector can therefore be accepted in the same cycle the last bit is popped.
- Load: `load = i_load_vld & o_load_rdy`. On load, `r_x <= i_load_x`.
- Next-state priority, highest first: `rst`, then `i_flush`, then `load`, then `pop`.
  - `rst` → `r_x <= 0`.
  - `i_flush` → `r_x <= 0`. Any concurrent load is dropped, even though `o_load_rdy` was high.
  - `load` → `r_x <= i_load_x`. This overrides the simultaneous last pop; the popped grant is still consumed by the downstream.
  - `pop` → clear the granted bit.
- All-zero load is accepted. `r_x` stays 0, no grant is produced, and the block remains IDLE.
- Full-ones load of width W produces exactly W grants, bit 0 first and bit W-1 last.
- Consumer stall (`i_y_rdy=0`): `o_y`, `o_y_vld` and `o_y_last` hold stable. No bit is skipped.
- `o_y_vld` never depends combinationally on `i_y_rdy`.
- `o_load_rdy` does depend combinationally on `i_y_rdy` (single-level path).

## Timing
- Reset values: `r_x=0`, `o_y_vld=0`, `o_y=0`, `o_y_last=0`, `o_load_rdy=1`, `o_y_idx=0`.
- Load latency: vector accepted on edge N → first grant valid in the cycle after edge N (one-cycle latency).
- Throughput: one grant per cycle while `i_y_rdy=1`.
- A vector with k set bits drains in k cycles. The next load is accepted in the cycle of the k-th pop, so there are zero bubbles between vectors.
- Flush: `o_y_vld=0` in the cycle after the flush edge.
- Reset mid-iteration: same as flush; the residue is lost. Reset also takes priority over a simultaneous load.

## Configuration
- Macro: `P_FFS_ITER_IDX_EN`.
- Defined:
  - `o_y_idx` port exists.
  - `o_y_idx` equals the bit position of `o_y`, computed combinationally from `r_x`.
  - `o_y_idx` is 0 when `o_y_vld=0`.
- Undefined:
  - Port omitted; no encoder logic.
  - All other behaviour is identical.

## Test plan
All scenarios use W=8.
- Reset, then load `8'b1010_0110` with `i_y_rdy=1` → grants `0x02`, `0x04`, `0x20`, `0x80` on four consecutive cycles. `o_y_last=1` only on `0x80`. `o_load_rdy=1` on that cycle. With IDX_EN, idx is 1, 2, 5, 7.
- Load `0x81`; hold `i_y_rdy=0` for 3 cycles, then 1 → `o_y=0x01` stable for 4 cycles, then `0x80`. No skipped or duplicate grant.
- Load `0x03`. On the cycle `0x02` pops, load `0x10` → next cycle `o_y=0x10`, with no idle cycle between vectors.
- Load `0x00` → `o_y_vld` stays 0 and `o_load_rdy` stays 1. A following load of `0xFF` → 8 grants, `0x01` through `0x80`.
- Load `0xF0`, pop one grant, assert `i_flush` together with `i_load_vld` (`0x0F`) → next cycle `o_y_vld=0` and the load is dropped.
- Load `0xFF`, pop two grants, assert `rst` → next cycle all outputs are at reset values, and a subsequent load of `0x40` yields a single grant `0x40` with `o_y_last=1`.
